// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel push-button debouncer with per-channel one-shot
// Optional feature macro: DEBOUNCE_SYNC_EN (two-flop input synchroniser per channel)
module debounce_multi #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 8,
    parameter int RISE_CLKS      = 34,
    parameter int FALL_CLKS      = 48,
    parameter int PULSE_CLKS     = 3,
    parameter int PULSE_ON_PRESS = 0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N_CH-1:0] BTN,
    output logic [N_CH-1:0] DB_LEVEL,
    output logic [N_CH-1:0] DB_PULSE,
    output logic            ANY_PULSE
);

    localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] RISE_C  = CNT_W'(RISE_CLKS);
    localparam logic [CNT_W-1:0] FALL_C  = CNT_W'(FALL_CLKS);
    localparam logic [CNT_W-1:0] PULSE_C = CNT_W'(PULSE_CLKS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam bit PULSE_PRESS = (PULSE_ON_PRESS != 0);

    // Reject parameter sets that would let a counter wrap or make a channel meaningless
    generate
        if (N_CH < 1) begin : g_bad_nch
            $error("debounce_multi: N_CH must be at least 1");
        end
        if (RISE_CLKS < 1 || longint'(RISE_CLKS) > CNT_MAX) begin : g_bad_rise
            $error("debounce_multi: RISE_CLKS out of range for CNT_W");
        end
        if (FALL_CLKS < 1 || longint'(FALL_CLKS) > CNT_MAX) begin : g_bad_fall
            $error("debounce_multi: FALL_CLKS out of range for CNT_W");
        end
        if (PULSE_CLKS < 1 || longint'(PULSE_CLKS) > CNT_MAX) begin : g_bad_pulse
            $error("debounce_multi: PULSE_CLKS out of range for CNT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_L2H  = 2'd1,
        ST_HIGH = 2'd2,
        ST_H2L  = 2'd3
    } state_t;

    logic [N_CH-1:0]  w_btn;
    state_t           r_state     [N_CH];
    state_t           w_state_nxt [N_CH];
    logic [CNT_W-1:0] r_cnt       [N_CH];
    logic [CNT_W-1:0] w_cnt_nxt   [N_CH];
    logic [CNT_W-1:0] r_pcnt      [N_CH];
    logic [CNT_W-1:0] w_pcnt_nxt  [N_CH];
    logic [N_CH-1:0]  w_trig;
    logic [N_CH-1:0]  r_level;
    logic [N_CH-1:0]  r_pulse;

`ifdef DEBOUNCE_SYNC_EN
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    // Two-flop synchroniser so BTN may be asynchronous to CLK
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn = r_sync2;
`else
    assign w_btn = BTN;
`endif

    // Next-state, debounce counter and one-shot counter for every channel
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = '0;
            w_trig[i]      = 1'b0;
            case (r_state[i])
                ST_LOW: begin
                    if (w_btn[i]) begin
                        w_state_nxt[i] = ST_L2H;
                        w_cnt_nxt[i]   = ONE_C;
                    end
                end
                ST_L2H: begin
                    if (!w_btn[i]) begin
                        w_state_nxt[i] = ST_LOW;
                    end else if (r_cnt[i] == RISE_C) begin
                        w_state_nxt[i] = ST_HIGH;
                        w_trig[i]      = PULSE_PRESS;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + ONE_C;
                    end
                end
                ST_HIGH: begin
                    if (!w_btn[i]) begin
                        w_state_nxt[i] = ST_H2L;
                        w_cnt_nxt[i]   = ONE_C;
                    end
                end
                ST_H2L: begin
                    if (w_btn[i]) begin
                        w_state_nxt[i] = ST_HIGH;
                    end else if (r_cnt[i] == FALL_C) begin
                        w_state_nxt[i] = ST_LOW;
                        w_trig[i]      = !PULSE_PRESS;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + ONE_C;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_LOW;
                end
            endcase

            // A trigger always reloads the full width, even mid-pulse
            if (w_trig[i]) begin
                w_pcnt_nxt[i] = PULSE_C;
            end else if (r_pcnt[i] != '0) begin
                w_pcnt_nxt[i] = r_pcnt[i] - ONE_C;
            end else begin
                w_pcnt_nxt[i] = '0;
            end
        end
    end

    // State, counters and registered outputs; reset aborts any activity in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_LOW;
                r_cnt[i]   <= '0;
                r_pcnt[i]  <= '0;
            end
            r_level <= '0;
            r_pulse <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_pcnt[i]  <= w_pcnt_nxt[i];
                r_level[i] <= (w_state_nxt[i] == ST_HIGH) || (w_state_nxt[i] == ST_H2L);
                r_pulse[i] <= (w_pcnt_nxt[i] != '0);
            end
        end
    end

    assign DB_LEVEL  = r_level;
    assign DB_PULSE  = r_pulse;
    assign ANY_PULSE = |r_pulse;

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi
module tb_debounce_multi;

`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [3:0] btn_p = 4'b0;
    logic [3:0] db_level, db_pulse, db_level_p, db_pulse_p;
    logic       any_pulse, any_pulse_p;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    debounce_multi u_dut (
        .CLK(clk), .RST_N(rst_n), .BTN(btn),
        .DB_LEVEL(db_level), .DB_PULSE(db_pulse), .ANY_PULSE(any_pulse)
    );

    debounce_multi #(
        .N_CH(4), .CNT_W(8), .RISE_CLKS(5), .FALL_CLKS(48),
        .PULSE_CLKS(2), .PULSE_ON_PRESS(1)
    ) u_dut_p (
        .CLK(clk), .RST_N(rst_n), .BTN(btn_p),
        .DB_LEVEL(db_level_p), .DB_PULSE(db_pulse_p), .ANY_PULSE(any_pulse_p)
    );

    always #5 clk = ~clk;

    // Expected {level, pulse} of a release-pulse channel held high over raw samples a..b
    function automatic logic [1:0] exp_rel(input int j, input int a, input int b);
        logic lvl, pul;
        lvl = (j >= a + 34 + LAT) && (j <= b + 48 + LAT);
        pul = (j >= b + 49 + LAT) && (j <= b + 51 + LAT);
        return {lvl, pul};
    endfunction

    task automatic test_reset();
        logic [8:0] got, exp;
        rst_n = 1'b0;
        btn   = 4'b1111;
        btn_p = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({db_level, db_pulse, any_pulse, db_level_p, db_pulse_p, any_pulse_p} !== 18'b0) begin
            failures++;
            $display("FAIL reset_hold got=%b/%b/%b exp=0", db_level, db_pulse, any_pulse);
        end
        btn   = 4'b0;
        btn_p = 4'b0;
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            exp_q.push_back(9'b0);
            @(posedge clk);
            #1;
            got = {db_level, db_pulse, any_pulse};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_press_release();
        logic [8:0] got, exp;
        logic [1:0] e0;
        for (int j = 0; j <= 160; j++) begin
            btn = {3'b0, (j < 100)};
            e0  = exp_rel(j, 0, 99);
            exp_q.push_back({3'b0, e0[1], 3'b0, e0[0], e0[0]});
            @(posedge clk);
            #1;
            got = {db_level, db_pulse, any_pulse};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL press_release cycle=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_high_glitch_restart();
        logic [8:0] got, exp;
        logic [1:0] e1;
        for (int j = 0; j <= 140; j++) begin
            btn = {2'b0, (j < 20) || (j >= 21 && j <= 80), 1'b0};
            e1  = exp_rel(j, 21, 80);
            exp_q.push_back({2'b0, e1[1], 1'b0, 2'b0, e1[0], 1'b0, e1[0]});
            @(posedge clk);
            #1;
            got = {db_level, db_pulse, any_pulse};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rise_glitch cycle=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_low_glitch();
        logic [8:0] got, exp;
        logic [1:0] e2;
        for (int j = 0; j <= 180; j++) begin
            btn = {1'b0, (j <= 49) || (j >= 97 && j <= 120), 2'b0};
            e2  = exp_rel(j, 0, 120);
            exp_q.push_back({1'b0, e2[1], 2'b0, 1'b0, e2[0], 2'b0, e2[0]});
            @(posedge clk);
            #1;
            got = {db_level, db_pulse, any_pulse};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL fall_glitch cycle=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous(input int off, input int any_len);
        logic [8:0] got, exp;
        logic [1:0] e0, e3;
        int any_cnt;
        any_cnt = 0;
        for (int j = 0; j <= 115; j++) begin
            btn = {(j >= off) && (j <= 49 + off), 2'b0, (j <= 49)};
            e0  = exp_rel(j, 0, 49);
            e3  = exp_rel(j, off, 49 + off);
            exp_q.push_back({e3[1], 2'b0, e0[1], e3[0], 2'b0, e0[0], e3[0] | e0[0]});
            @(posedge clk);
            #1;
            got = {db_level, db_pulse, any_pulse};
            if (any_pulse === 1'b1) any_cnt++;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL simultaneous off=%0d cycle=%0d got=%b exp=%b", off, j, got, exp);
            end
        end
        checks++;
        if (any_cnt !== any_len) begin
            failures++;
            $display("FAIL any_pulse_width off=%0d got=%0d exp=%0d", off, any_cnt, any_len);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [8:0] got, exp;
        logic [1:0] e0;
        for (int j = 0; j <= 99 + LAT; j++) begin
            btn = {3'b0, (j <= 49) || (j >= 99)};
            e0  = exp_rel(j, 0, 49);
            exp_q.push_back({3'b0, e0[1], 3'b0, e0[0], e0[0]});
            @(posedge clk);
            #1;
            got = {db_level, db_pulse, any_pulse};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pre_reset cycle=%0d got=%b exp=%b", j, got, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({db_level, db_pulse, any_pulse} !== 9'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0", {db_level, db_pulse, any_pulse});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j <= 105; j++) begin
            btn = {3'b0, (j <= 45)};
            e0  = exp_rel(j, 0, 45);
            exp_q.push_back({3'b0, e0[1], 3'b0, e0[0], e0[0]});
            @(posedge clk);
            #1;
            got = {db_level, db_pulse, any_pulse};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL post_reset cycle=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_pulse_on_press();
        logic [8:0] got, exp;
        logic lvl, pul;
        for (int j = 0; j <= 90; j++) begin
            btn_p = {3'b0, (j <= 29)};
            lvl = (j >= 5 + LAT) && (j <= 77 + LAT);
            pul = (j >= 5 + LAT) && (j <= 6 + LAT);
            exp_q.push_back({3'b0, lvl, 3'b0, pul, pul});
            @(posedge clk);
            #1;
            got = {db_level_p, db_pulse_p, any_pulse_p};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pulse_on_press cycle=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_high_glitch_restart();
        test_low_glitch();
        test_simultaneous(0, 3);
        test_simultaneous(2, 5);
        test_reset_mid_pulse();
        test_pulse_on_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel push-button debouncer and one-shot generator for the board-level button inputs. Each channel runs an independent debounce FSM that produces:
- a settled level output;
- a fixed-width one-shot pulse on the settled press or release edge, selectable by parameter.

It replaces per-button single-channel debouncers and feeds the interrupt and MMIO input logic.

Parameters:
- N_CH, 4: number of independent button channels.
- CNT_W, 8: width of each per-channel counter.
- RISE_CLKS, 34: number of additional consecutive high samples, after the first high sample, that qualify a press.
- FALL_CLKS, 48: number of additional consecutive low samples, after the first low sample, that qualify a release.
- PULSE_CLKS, 3: one-shot width in clocks.
- PULSE_ON_PRESS, 0: 0 = pulse on settled release; 1 = pulse on settled press.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- BTN  in  N_CH  raw button inputs.
- DB_LEVEL  out  N_CH  debounced level per channel (registered).
- DB_PULSE  out  N_CH  one-shot per channel (registered).
- ANY_PULSE  out  1  OR-reduction of DB_PULSE.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - all FSMs go to LOW; all counters go to 0.
  - DB_LEVEL=0, DB_PULSE=0, ANY_PULSE=0 immediately.
  - Reset mid-debounce or mid-pulse aborts that activity; nothing is held over.
- Per-channel FSM states: LOW, LOW_TO_HIGH, HIGH, HIGH_TO_LOW. The debounce counter is cnt.
  - LOW: if BTN=1, go to LOW_TO_HIGH with cnt=1. Otherwise stay, cnt=0.
  - LOW_TO_HIGH:
    - BTN=0: go to LOW, cnt=0.
    - BTN=1 and cnt==RISE_CLKS: go to HIGH, cnt=0.
    - otherwise: cnt+1.
  - HIGH: if BTN=0, go to HIGH_TO_LOW with cnt=1. Otherwise stay, cnt=0.
  - HIGH_TO_LOW:
    - BTN=1: go to HIGH, cnt=0.
    - BTN=0 and cnt==FALL_CLKS: go to LOW, cnt=0.
    - otherwise: cnt+1.
- Press timing: if the first high sample is at edge k and BTN stays high, DB_LEVEL goes to 1 after edge k+RISE_CLKS. This requires RISE_CLKS+1 consecutive high samples.
- Release timing: if the first low sample is at edge k, DB_LEVEL goes to 0 after edge k+FALL_CLKS.
- DB_LEVEL=1 in HIGH and HIGH_TO_LOW; it is 0 otherwise.
- Glitch handling:
  - A low glitch shorter than FALL_CLKS+1 samples while HIGH produces no level change and no pulse.
  - A high glitch shorter than RISE_CLKS+1 samples while LOW produces no level change and no pulse.
- One-shot:
  - A separate pulse counter per channel is triggered on the settled edge selected by PULSE_ON_PRESS: the LOW_TO_HIGH→HIGH transition (PULSE_ON_PRESS=1) or the HIGH_TO_LOW→LOW transition (PULSE_ON_PRESS=0).
  - DB_PULSE goes to 1 after the trigger edge, the same edge at which DB_LEVEL changes, and stays high for exactly PULSE_CLKS cycles.
  - A new trigger while a pulse is active restarts the full PULSE_CLKS width; pulses never merge silently or truncate.
  - The FSM accepts new input during a pulse, so a press can begin debouncing while the release pulse is still high.
- Channels are fully independent. Simultaneous events on multiple channels each produce their own pulse; ANY_PULSE is high while any DB_PULSE bit is high.
- Counters never wrap, because comparisons stop counting at the limit.
- Elaboration error if any of the following holds:
  - RISE_CLKS or FALL_CLKS is 0, or is greater than 2^CNT_W-1;
  - PULSE_CLKS is 0, or is greater than 2^CNT_W-1;
  - N_CH < 1.

Optional Feature:
DEBOUNCE_SYNC_EN:
- Defined: each BTN bit passes through a two-flop synchroniser (reset to 0) before the FSM. All press and release timings above gain exactly 2 cycles of latency, and BTN may be fully asynchronous to CLK.
- Undefined: BTN is sampled directly; the instantiator guarantees BTN is synchronous to CLK.

Test Plan:
1. Defaults, BTN[0] driven to 1 at edge 10 and held for 100 cycles, then 0 → DB_LEVEL[0] rises after edge 44 and falls 48 edges after the first low sample. DB_PULSE[0] is high for exactly 3 cycles starting at that same fall edge. ANY_PULSE mirrors DB_PULSE[0]; channels 1–3 stay 0.
2. BTN[1] high 20 cycles, low 1 cycle, high 60 cycles → no DB_LEVEL[1] change during the first run; DB_LEVEL[1] rises 34 edges after the start of the second run.
3. Settled high on BTN[2], then low for 47 cycles, then high again → DB_LEVEL[2] stays 1 and DB_PULSE[2] stays 0.
4. BTN[0] and BTN[3] pressed and released with identical timing → both DB_PULSE bits are high in the same 3 cycles and ANY_PULSE is high for those 3 cycles. Offset BTN[3] by 2 cycles → ANY_PULSE is high for 5 cycles.
5. Assert RST_N=0 during the second pulse cycle while BTN[0]=1 → all outputs are 0 immediately. After reset release with BTN still high, DB_LEVEL[0] rises after edge 34 counted from the first post-reset edge; no pulse is emitted until the next release.
6. PULSE_ON_PRESS=1, RISE_CLKS=5, PULSE_CLKS=2, with and without DEBOUNCE_SYNC_EN → a 2-cycle pulse coincides with the DB_LEVEL rise and no pulse occurs on release. With the macro defined, the rise occurs 2 cycles later.
